// File: rtl/branch_fu_if.sv
// rtl/branch_fu_if.sv - branch FU bundle: RS issue/resp handshake, flush, CDB lane 3 outputs
interface branch_fu_if #(
  parameter int ROB_DEPTH = 4
);
  localparam int TW = $clog2(ROB_DEPTH);

  // Pipeline control and RS issue side
  logic          flush;
  logic          comp_issue;
  logic [TW-1:0] tag_dest_in;
  logic [31:0]   instr_in;
  logic [31:0]   data_A_in;
  logic [31:0]   data_B_in;
  logic [31:0]   pc_in;
  logic [31:0]   imm_in;
  logic          resp;

  // CDB lane and branch resolution side
  logic          cdb_req;
  logic          cdb_gnt;
  logic          cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic [31:0]   cdb_data;
  logic          br_taken;
  logic [31:0]   br_target;
  logic          busy;

  // Environment view: reservation station, CDB arbiter and flush source
  modport master (
    output flush, comp_issue, tag_dest_in, instr_in, data_A_in, data_B_in,
           pc_in, imm_in, cdb_gnt,
    input  resp, cdb_req, cdb_valid, cdb_tag, cdb_data, br_taken, br_target,
           busy
  );

  // Functional unit view
  modport slave (
    input  flush, comp_issue, tag_dest_in, instr_in, data_A_in, data_B_in,
           pc_in, imm_in, cdb_gnt,
    output resp, cdb_req, cdb_valid, cdb_tag, cdb_data, br_taken, br_target,
           busy
  );
endinterface

// File: rtl/branch_fu.sv
// rtl/branch_fu.sv - branch/jump resolution unit feeding CDB lane 3
module branch_fu #(
  parameter int ROB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  branch_fu_if.slave  bus
);
  localparam int TW = $clog2(ROB_DEPTH);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    BCAST = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          capture;
  logic          bcast;

  // Operand registers; only the opcode and funct3 fields of the word matter
  logic [TW-1:0] tag_q;
  logic [6:0]    op_q;
  logic [2:0]    f3_q;
  logic [31:0]   a_q, b_q, pc_q, imm_q;

  // Resolved results, held for the whole broadcast residency
  logic          taken_q, taken_d;
  logic [31:0]   target_q, target_d;
  logic [31:0]   data_q, data_d;

  // Arithmetic shared by the resolution logic (all modulo 2^32)
  logic [31:0]   pc_plus_imm, pc_plus_4, jalr_target;
  logic          eq, lt_s, lt_u;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, capture strobe and CDB handshake; flush wins over grant
  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    bus.cdb_req = 1'b0;
    bus.resp    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.comp_issue && !bus.flush) begin
          capture = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = bus.flush ? IDLE : BCAST;
      end
      BCAST: begin
        bus.cdb_req = 1'b1;
        if (bus.flush) begin
          state_d = IDLE;
        end else if (bus.cdb_gnt) begin
          bus.resp = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture when an issue is accepted in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q <= '0;
      op_q  <= '0;
      f3_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      pc_q  <= '0;
      imm_q <= '0;
    end else if (capture) begin
      tag_q <= bus.tag_dest_in;
      op_q  <= bus.instr_in[6:0];
      f3_q  <= bus.instr_in[14:12];
      a_q   <= bus.data_A_in;
      b_q   <= bus.data_B_in;
      pc_q  <= bus.pc_in;
      imm_q <= bus.imm_in;
    end
  end

  assign pc_plus_imm = pc_q + imm_q;
  assign pc_plus_4   = pc_q + 32'd4;
  assign jalr_target = (a_q + imm_q) & ~32'h1;
  assign eq          = (a_q == b_q);
  assign lt_s        = ($signed(a_q) < $signed(b_q));
  assign lt_u        = (a_q < b_q);

  // Resolve taken/target/link; unknown encodings fall through as not-taken
  always_comb begin
    taken_d  = 1'b0;
    target_d = pc_plus_4;
    data_d   = 32'h0;
    case (op_q)
      OP_BRANCH: begin
        case (f3_q)
          3'b000:  taken_d = eq;
          3'b001:  taken_d = !eq;
          3'b100:  taken_d = lt_s;
          3'b101:  taken_d = !lt_s;
          3'b110:  taken_d = lt_u;
          3'b111:  taken_d = !lt_u;
          default: taken_d = 1'b0;
        endcase
        if (taken_d) begin
          target_d = pc_plus_imm;
        end
      end
      OP_JAL: begin
        taken_d  = 1'b1;
        target_d = pc_plus_imm;
        data_d   = pc_plus_4;
      end
      OP_JALR: begin
        taken_d  = 1'b1;
        target_d = jalr_target;
        data_d   = pc_plus_4;
      end
      default: begin
        taken_d  = 1'b0;
        target_d = pc_plus_4;
        data_d   = 32'h0;
      end
    endcase
  end

  // Result registers load once, in EXEC, so BCAST outputs never move
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_q  <= 1'b0;
      target_q <= '0;
      data_q   <= '0;
    end else if (state_q == EXEC) begin
      taken_q  <= taken_d;
      target_q <= target_d;
      data_q   <= data_d;
    end
  end

  assign bcast         = (state_q == BCAST);
  assign bus.cdb_valid = bus.resp;
  assign bus.cdb_tag   = bcast ? tag_q    : '0;
  assign bus.cdb_data  = bcast ? data_q   : '0;
  assign bus.br_taken  = bcast ? taken_q  : 1'b0;
  assign bus.br_target = bcast ? target_q : '0;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/branch_fu.md
# branch_fu

Branch functional unit: the execute-side responder to the branch reservation station's `comp_issue`/`resp` handshake. It captures one issued control-flow instruction (BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR), resolves taken/target, and requests a CDB slot. When the slot is granted it broadcasts the link value and resolution to the ROB and pulses `resp` back to the reservation station. It sits between the branch RS and CDB lane 3 of the 4-lane CDB.

## Interface
- `ROB_DEPTH`, 4, ROB entries; tag width `TW = $clog2(ROB_DEPTH)`.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  synchronous pipeline flush.
- `comp_issue`  in  1  RS has a valid instruction on its outputs; held until `resp`.
- `tag_dest_in`  in  TW  ROB tag of the instruction.
- `instr_in`  in  32  raw instruction word.
- `data_A_in`, `data_B_in`  in  32  rs1/rs2 values.
- `pc_in`, `imm_in`  in  32  instruction PC and decoded immediate.
- `resp`  out  1  one-cycle completion pulse to RS; equals `cdb_req & cdb_gnt`.
- `cdb_req`  out  1  request for CDB lane.
- `cdb_gnt`  in  1  grant from CDB arbiter, same-cycle.
- `cdb_valid`  out  1  broadcast valid (= `resp`).
- `cdb_tag`  out  TW  broadcast ROB tag.
- `cdb_data`  out  32  rd value: `pc+4` for JAL/JALR, 0 otherwise.
- `br_taken`  out  1  resolved taken (JAL/JALR always 1).
- `br_target`  out  32  redirect PC when taken, else `pc+4`.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, EXEC, BCAST.
- IDLE: if `comp_issue` and not `flush`, latch tag/instr/A/B/pc/imm into operand registers; -> EXEC.
- EXEC: decode opcode/funct3 from latched instr; compute and register `br_taken`, `br_target`, `cdb_data`; -> BCAST.
  - Branch (opcode 1100011): funct3 000 eq, 001 ne, 100 signed lt, 101 signed ge, 110 unsigned lt, 111 unsigned ge; target `pc+imm`.
  - JAL (1101111): taken, target `pc+imm`. JALR (1100111): taken, target `(A+imm) & ~32'h1`.
  - Illegal funct3 (010/011) or other opcode: not taken, target `pc+4`, `cdb_data` 0; still broadcasts so the ROB entry retires.
  - All adds modulo 2^32; overflow discarded.
- BCAST: `cdb_req`=1, all CDB/branch outputs held stable. On `cdb_gnt`: `resp`=`cdb_valid`=1 this cycle; -> IDLE. Without grant: stay, unbounded.
- IDLE ignores `comp_issue` in the cycle after `resp` only because RS drops it on that edge; no extra guard required, but the FU never captures while not in IDLE.
- `flush` (any state): -> IDLE next edge, `cdb_req` deasserted next cycle, no `resp`; if `flush` and `cdb_gnt` coincide in BCAST, `resp`/`cdb_valid` are forced 0.
- `rst` mid-operation: immediate return to IDLE, outputs to reset values.

## Timing
- Reset values: state IDLE; `resp`, `cdb_req`, `cdb_valid`, `br_taken`, `busy` 0; `cdb_tag`, `cdb_data`, `br_target` 0.
- Cycle N: `comp_issue` sampled in IDLE. N+1: EXEC. N+2: BCAST, `cdb_req`=1. Earliest `resp` at N+2 (grant same cycle); min issue-to-issue 3 cycles + grant stall.
- `resp` and `cdb_valid` are combinational from `cdb_gnt`; outputs are registered and unchanged for the whole BCAST residency.
- CDB outputs other than `cdb_valid` are don't-care outside BCAST but driven 0.

## Test plan
- BEQ A=5 B=5 pc=0x100 imm=0x20, gnt tied 1 -> `resp` at N+2, taken=1, target=0x120, cdb_data=0, tag echoed.
- BLT A=0xFFFFFFFF B=1 then BLTU same operands -> first taken (signed -1<1), second not taken, target=pc+4.
- JALR A=0x1003 imm=0x4 pc=0x200 -> target=0x1006 (bit0 cleared), cdb_data=0x204, taken=1.
- BNE, `cdb_gnt` held 0 for 5 cycles then 1 -> `cdb_req` high 6 cycles, outputs stable, single `resp` pulse.
- JAL in BCAST with `flush` and `cdb_gnt` both 1 -> no `resp`/`cdb_valid`, IDLE next cycle; next `comp_issue` accepted normally.
- Async `rst` asserted mid-EXEC (between edges) -> `busy`, `cdb_req` 0 immediately; illegal funct3 010 after reset -> broadcast with taken=0, data 0.
